// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// operation codes, FSM states and default widths matching the register file.
package mul_div_unit_pkg;

    localparam int MDU_WIDTH = 16;
    localparam int MDU_AW    = 3;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIVU = 2'b10,
        OP_REMU = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// Bit-serial datapath: MSB-first shift-add multiply and restoring divide.
// result_d_o is the result as it will be once the current cycle's update lands.
module mdu_datapath
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_d_o
);

    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;

    // opa doubles as multiplicand / dividend-then-quotient; opb as multiplier / divisor
    always_comb begin
        op_d   = op_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        acc_d  = acc_q;
        rem_d  = rem_q;
        addend = opb_q[WIDTH-1] ? {{WIDTH{1'b0}}, opa_q} : '0;
        trial  = (rem_q << 1) | {{WIDTH{1'b0}}, opa_q[WIDTH-1]};
        diff   = trial - {1'b0, opb_q};
        if (load_i) begin
            op_d  = op_i;
            opa_d = a_i;
            opb_d = b_i;
            acc_d = '0;
            rem_d = '0;
        end else if (step_i) begin
            if (op_q[1]) begin
                rem_d = diff[WIDTH] ? trial : diff;
                opa_d = {opa_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc_d = (acc_q << 1) + addend;
                opb_d = opb_q << 1;
            end
        end
    end

    always_comb begin
        result_d_o = '0;
        if (load_i) begin
            if (op_i[1] && (b_i == '0)) begin
                result_d_o = (op_i == OP_REMU) ? a_i : '1;
            end
        end else begin
            unique case (op_q)
                OP_MUL:  result_d_o = acc_d[WIDTH-1:0];
                OP_MULH: result_d_o = acc_d[2*WIDTH-1:WIDTH];
                OP_DIVU: result_d_o = opa_d;
                OP_REMU: result_d_o = rem_d[WIDTH-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
            rem_q <= '0;
        end else begin
            op_q  <= op_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MUL/MULH/DIVU/REMU unit between register-file read and write ports.
// One bit per cycle, then a single-cycle writeback strobe.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int AW    = MDU_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dest,
    output logic             busy,
    output logic             regWrite,
    output logic [AW-1:0]    waddr,
    output logic [WIDTH-1:0] wdata
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    dest_q;
    logic [AW-1:0]    waddr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             load;
    logic             step;
    logic             div0;
    logic [WIDTH-1:0] result_d;

    assign div0 = op[1] && (b == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (div0) begin
                        cnt_d   = '0;
                        state_d = S_WB;
                    end else begin
                        cnt_d   = CW'(WIDTH);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result and address are captured on entry to WB so they hold afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                dest_q <= dest;
            end
            if ((state_d == S_WB) && (state_q != S_WB)) begin
                wdata_q <= result_d;
                waddr_q <= load ? dest : dest_q;
            end
        end
    end

    mdu_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .step_i     (step),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .result_d_o (result_d)
    );

    assign busy     = (state_q != S_IDLE);
    assign regWrite = (state_q == S_WB);
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

endmodule
